// File: rtl/dtack_pkg.sv
// Shared types and constants for the DTACK generator: FSM states, the IACK
// function code and the synchroniser depth.
package dtack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    FOREIGN = 2'd3
  } state_t;

  localparam logic [2:0] FC_IACK    = 3'b111;
  localparam int         SYNC_DEPTH = 2;

  function automatic logic addr_match(input logic [23:1] a,
                                      input logic [23:1] base,
                                      input logic [23:1] mask);
    return ((a ^ base) & mask) == 23'd0;
  endfunction

endpackage

// File: rtl/dtack_gen_if.sv
// 68000 asynchronous bus signals seen by the DTACK generator, plus the
// open-drain enables and select/marker outputs it produces.
interface dtack_gen_if;

  logic        as;
  logic        uds;
  logic        lds;
  logic        rw;
  logic [2:0]  fc;
  logic [23:1] a;
  logic        dtack;

  logic        dtack_oe;
  logic        berr_oe;
  logic        sel;
  logic        tp1;

  modport master (
    output as, uds, lds, rw, fc, a, dtack,
    input  dtack_oe, berr_oe, sel, tp1
  );

  modport slave (
    input  as, uds, lds, rw, fc, a, dtack,
    output dtack_oe, berr_oe, sel, tp1
  );

endinterface

// File: rtl/bus_sync.sv
// Multi-bit flop-chain synchroniser for active-low bus strobes; resets to
// all ones so every strobe reads as negated until real samples arrive.
module bus_sync
  import dtack_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '1;
    end else begin
      pipe <= {pipe[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = pipe[SYNC_DEPTH-1];

endmodule

// File: rtl/dtack_gen.sv
// Decodes one 68000 address window, inserts wait states and drives DTACK,
// with a bus watchdog that raises BERR on unterminated non-IACK cycles.
module dtack_gen
  import dtack_pkg::*;
#(
  parameter logic [23:1] BASE_ADDR   = 23'h7F0000,
  parameter logic [23:1] ADDR_MASK   = 23'h7F8000,
  parameter int          WAIT_STATES = 2,
  parameter int          TIMEOUT     = 64
) (
  input logic        clk,
  input logic        rst,
  dtack_gen_if.slave bus
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("dtack_gen: WAIT_STATES must be 0..15");
  end
  if (TIMEOUT < 16 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dtack_gen: TIMEOUT must be 16..255");
  end
  if (!(WAIT_STATES + 3 < TIMEOUT)) begin : g_bad_ratio
    $error("dtack_gen: WAIT_STATES+3 must be below TIMEOUT");
  end

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [7:0] WD_LIMIT  = 8'(TIMEOUT);
  localparam logic [1:0] FILL_DONE = 2'(SYNC_DEPTH);

  logic [3:0]  sync_q;
  logic        as_s;
  logic        uds_s;
  logic        lds_s;
  logic        dtack_s;

  logic [1:0]  fill;
  logic        armed;

  logic        cap_valid;
  logic [23:1] cap_a;
  logic [2:0]  cap_fc;
  logic [23:1] dec_a;
  logic [2:0]  dec_fc;
  logic        addr_hit;
  logic        iack;
  logic        strobe;

  state_t      state;
  state_t      next_state;
  logic [3:0]  wait_cnt;

  logic [7:0]  wd_cnt;
  logic        wd_run;
  logic        berr;

  bus_sync #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({bus.as, bus.uds, bus.lds, bus.dtack}),
    .q   (sync_q)
  );

  assign {as_s, uds_s, lds_s, dtack_s} = sync_q;

  // The synchroniser resets to "AS high", so only trust an AS-high sighting
  // once real samples have filled it; this keeps us off a half-finished cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (fill != FILL_DONE) begin
        fill <= fill + 2'd1;
      end
      if (fill == FILL_DONE && as_s) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_a     <= '0;
      cap_fc    <= '0;
    end else if (state != IDLE || as_s) begin
      cap_valid <= 1'b0;
    end else if (armed && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_a     <= bus.a;
      cap_fc    <= bus.fc;
    end
  end

  // On the first AS-low edge the capture registers are still loading.
  assign dec_a    = cap_valid ? cap_a  : bus.a;
  assign dec_fc   = cap_valid ? cap_fc : bus.fc;
  assign addr_hit = addr_match(dec_a, BASE_ADDR, ADDR_MASK);
  assign iack     = (dec_fc == FC_IACK);
  assign strobe   = !uds_s || !lds_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == WAIT) begin
        wait_cnt <= WAIT_INIT;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (armed && !as_s) begin
          if (!addr_hit || iack) begin
            next_state = FOREIGN;
          end else if (strobe) begin
            next_state = (WAIT_STATES == 0) ? ACK : WAIT;
          end
        end
      end
      WAIT: begin
        if (as_s) begin
          next_state = IDLE;
        end else if (wait_cnt <= 4'd1) begin
          next_state = ACK;
        end
      end
      ACK, FOREIGN: begin
        if (as_s) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.dtack_oe = (state == ACK) && !berr;
    bus.sel      = (state == WAIT) || (state == ACK);
    bus.tp1      = (state == WAIT) || (state == ACK);
    bus.berr_oe  = berr;
  end

  // Any agent's DTACK ends the cycle from the watchdog's point of view.
  assign wd_run = !as_s && dtack_s && (bus.fc != FC_IACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= 8'd0;
      berr   <= 1'b0;
    end else begin
      if (!wd_run) begin
        wd_cnt <= 8'd0;
      end else if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
      if (as_s) begin
        berr <= 1'b0;
      end else if (wd_run && wd_cnt == WD_LIMIT - 8'd1) begin
        berr <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dtack_gen.md
Name: dtack_gen

Overview:
- Active bus-response stage that sits downstream of the passive bus-observation block on the 68k CPLD devboard.
- Watches the 68000 asynchronous bus and decodes one address window.
- For cycles in that window, inserts a programmable number of wait states, then asserts DTACK and holds it until AS negates.
- A bus watchdog asserts BERR for any non-IACK cycle left unterminated for too long; TP1 gives a scope-visible cycle marker.

Parameters:
- BASE_ADDR, 23'h7F0000, window base; compared against A[23:1].
- ADDR_MASK, 23'h7F8000, 1 = bit participates in the decode.
- WAIT_STATES, 2, CLK cycles between decode and DTACK assertion (0..15).
- TIMEOUT, 64, CLK cycles from AS assertion to BERR (16..255).

Ports:
- CLK  in  1  CPU clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset. The top level inverts the board /RESET line.
- AS  in  1  address strobe, active-low.
- UDS  in  1  upper data strobe, active-low.
- LDS  in  1  lower data strobe, active-low.
- RW  in  1  1 = read.
- FC  in  3  function code.
- A  in  23  address bus A[23:1].
- DTACK  in  1  bus DTACK level (active-low), for watchdog termination sensing.
- DTACK_OE  out  1  1 = drive /DTACK low (open-drain enable at top).
- BERR_OE  out  1  1 = drive /BERR low.
- SEL  out  1  1 = current cycle decoded to window (chip-select to local device).
- TP1  out  1  high for the whole duration of a decoded cycle.

Behaviour:
- Reset (async, RESET=1): state=IDLE; DTACK_OE=0, BERR_OE=0, SEL=0, TP1=0; counters=0.
- Input sampling:
  - AS, UDS, LDS and DTACK pass through 2-flop synchronisers; A, FC and RW are sampled raw.
  - Decode uses A, FC and RW values captured on the edge that first sees synced AS low.
- Hit condition: ((A ^ BASE_ADDR) & ADDR_MASK)==0, FC != 3'b111 (IACK excluded), and at least one of UDS/LDS synced low (read or write).
- FSM:
  - IDLE: when synced AS goes low, capture address. On hit, go to WAIT, set wait counter to WAIT_STATES, SEL=1, TP1=1. On miss, go to FOREIGN.
  - WAIT: decrement the counter each cycle; at 0 go to ACK. If WAIT_STATES=0, go from IDLE to ACK directly, so DTACK_OE rises 1 cycle after the capture edge.
  - ACK: DTACK_OE=1. Hold until synced AS high, then go to IDLE, clearing DTACK_OE, SEL and TP1 on that same edge.
  - FOREIGN: no drive; wait for synced AS high, then go to IDLE.
- AS negated mid-WAIT (aborted cycle): return to IDLE immediately. DTACK_OE is never asserted; SEL and TP1 clear.
- Write cycles where UDS/LDS assert after AS: the hit is qualified on the first cycle with AS and a data strobe both low. IDLE waits up to the strobe's arrival without treating the cycle as a miss.
- Watchdog:
  - A separate 8-bit counter runs while synced AS is low, and clears when AS is high or synced DTACK is low (any agent terminated).
  - When the count reaches TIMEOUT, BERR_OE=1 and holds until synced AS is high.
  - The count saturates and never wraps.
  - The watchdog is disabled for IACK cycles (autovector/VPA handled elsewhere).
- DTACK_OE and BERR_OE are never both 1. Because the FSM asserts DTACK before TIMEOUT, this holds whenever WAIT_STATES+3 < TIMEOUT, which is checked by an elaboration-time assertion.
- Back-to-back cycles: the FSM must observe AS high for at least 1 synced cycle before a new capture.
- RESET asserted mid-cycle drops all outputs asynchronously; after release, the FSM stays in IDLE until AS is first seen high. This prevents acking a half-cycle.

Decomposition:
- Package dtack_pkg holds the FSM state enum (IDLE, WAIT, ACK, FOREIGN), FC_IACK=3'b111, and the sync depth constant.
- One sub-module, bus_sync: a parameterised-width 2-flop synchroniser with async reset to 1 (inactive level), instanced for AS, UDS, LDS and DTACK.

Test Plan:
- Read at A=23'h7F0010, FC=101, WAIT_STATES=2 -> SEL/TP1 rise 3 CLK after AS low; DTACK_OE rises 2 CLK later; all clear 3 CLK after AS high.
- Access at A=23'h000100 (miss) -> DTACK_OE, SEL and TP1 stay 0. With an external DTACK pulled at cycle 5, BERR_OE stays 0.
- Miss with no external DTACK, TIMEOUT=64 -> BERR_OE=1 exactly 64 CLK after synced AS low; clears 3 CLK after AS high; counter saturates, no wrap.
- Hit cycle with AS negated during WAIT -> DTACK_OE never asserts; FSM back in IDLE; next cycle is handled normally.
- IACK cycle, FC=111, with address inside the window -> no SEL, no DTACK_OE, no BERR_OE even after 300 CLK.
- RESET pulse mid-ACK -> all outputs 0 asynchronously. After release with AS still low, no DTACK until AS goes high and a new hit cycle begins.
